// File: rtl/ram_arbiter.sv
// Purpose : shares one single-port audio RAM between the CPU and the DSP engine; DSP has fixed priority and a wait counter bounds CPU starvation.
// Latency : req to ack 1 cycle minimum, req to read_valid 2 cycles minimum; one RAM access issued per clock at most.
// Backpressure: requesters hold req until their ack pulse; a req seen during its own ack cycle is ignored.
//
// Ports:
//   clock, reset                    system clock, synchronous active-high reset
//   in_cpu_* / in_dsp_*             request, address, write data, write enable per requester
//   out_cpu_* / out_dsp_*           ack pulse, read data, read-valid pulse per requester
//   out_ram_*                       registered RAM address, write data, write strobe
//   in_ram_read                     RAM read data for the address currently on out_ram_address
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_CPU_WAIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_cpu_req,
  input  logic [ADDR_WIDTH-1:0] in_cpu_address,
  input  logic [DATA_WIDTH-1:0] in_cpu_write,
  input  logic                  in_cpu_write_enable,
  output logic                  out_cpu_ack,
  output logic [DATA_WIDTH-1:0] out_cpu_read,
  output logic                  out_cpu_read_valid,
  input  logic                  in_dsp_req,
  input  logic [ADDR_WIDTH-1:0] in_dsp_address,
  input  logic [DATA_WIDTH-1:0] in_dsp_write,
  input  logic                  in_dsp_write_enable,
  output logic                  out_dsp_ack,
  output logic [DATA_WIDTH-1:0] out_dsp_read,
  output logic                  out_dsp_read_valid,
  output logic [ADDR_WIDTH-1:0] out_ram_address,
  output logic [DATA_WIDTH-1:0] out_ram_write,
  output logic                  out_ram_write_enable,
  input  logic [DATA_WIDTH-1:0] in_ram_read
);

  localparam int WAIT_W = (MAX_CPU_WAIT < 2) ? 1 : $clog2(MAX_CPU_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

  logic              eff_cpu;
  logic              eff_dsp;
  logic              grant_cpu;
  logic              grant_dsp;
  logic [WAIT_W-1:0] cpu_wait;
  logic [WAIT_W-1:0] cpu_wait_nxt;
  // A read was issued to the RAM this cycle; its data is captured at the end of it.
  logic              cpu_rd_pend;
  logic              dsp_rd_pend;

  always_comb begin
    // Masking with the own ack forces a gap cycle, which is what lets the
    // other side in when both hold req continuously.
    eff_cpu   = in_cpu_req & ~out_cpu_ack;
    eff_dsp   = in_dsp_req & ~out_dsp_ack;
    grant_cpu = eff_cpu & (~eff_dsp | (cpu_wait == WAIT_MAX));
    grant_dsp = eff_dsp & ~grant_cpu;

    cpu_wait_nxt = cpu_wait;
    if (grant_cpu || !in_cpu_req) begin
      cpu_wait_nxt = '0;
    end else if (eff_cpu && eff_dsp && (cpu_wait != WAIT_MAX)) begin
      cpu_wait_nxt = cpu_wait + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_wait             <= '0;
      out_cpu_ack          <= 1'b0;
      out_dsp_ack          <= 1'b0;
      out_ram_address      <= '0;
      out_ram_write        <= '0;
      out_ram_write_enable <= 1'b0;
      cpu_rd_pend          <= 1'b0;
      dsp_rd_pend          <= 1'b0;
      out_cpu_read         <= '0;
      out_cpu_read_valid   <= 1'b0;
      out_dsp_read         <= '0;
      out_dsp_read_valid   <= 1'b0;
    end else begin
      cpu_wait    <= cpu_wait_nxt;
      out_cpu_ack <= grant_cpu;
      out_dsp_ack <= grant_dsp;
      cpu_rd_pend <= grant_cpu & ~in_cpu_write_enable;
      dsp_rd_pend <= grant_dsp & ~in_dsp_write_enable;

      // Address and data hold when idle; only the write strobe drops.
      out_ram_write_enable <= 1'b0;
      if (grant_cpu) begin
        out_ram_address      <= in_cpu_address;
        out_ram_write        <= in_cpu_write;
        out_ram_write_enable <= in_cpu_write_enable;
      end else if (grant_dsp) begin
        out_ram_address      <= in_dsp_address;
        out_ram_write        <= in_dsp_write;
        out_ram_write_enable <= in_dsp_write_enable;
      end

      out_cpu_read_valid <= cpu_rd_pend;
      out_dsp_read_valid <= dsp_rd_pend;
      if (cpu_rd_pend) begin
        out_cpu_read <= in_ram_read;
      end
      if (dsp_rd_pend) begin
        out_dsp_read <= in_ram_read;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose : randomized bench for ram_arbiter against a transaction-level reference model.
// Latency : checks every DUT output each cycle, 1 time unit after the rising edge.
// Backpressure: bench requesters hold req until the model predicts their ack.
module tb_ram_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXW = 3;
  localparam int NCYC = 1500;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_cpu_req, in_cpu_write_enable, out_cpu_ack, out_cpu_read_valid;
  logic [AW-1:0] in_cpu_address;
  logic [DW-1:0] in_cpu_write, out_cpu_read;
  logic          in_dsp_req, in_dsp_write_enable, out_dsp_ack, out_dsp_read_valid;
  logic [AW-1:0] in_dsp_address;
  logic [DW-1:0] in_dsp_write, out_dsp_read;
  logic [AW-1:0] out_ram_address;
  logic [DW-1:0] out_ram_write, in_ram_read;
  logic          out_ram_write_enable;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CPU_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .in_cpu_req(in_cpu_req), .in_cpu_address(in_cpu_address), .in_cpu_write(in_cpu_write),
    .in_cpu_write_enable(in_cpu_write_enable), .out_cpu_ack(out_cpu_ack),
    .out_cpu_read(out_cpu_read), .out_cpu_read_valid(out_cpu_read_valid),
    .in_dsp_req(in_dsp_req), .in_dsp_address(in_dsp_address), .in_dsp_write(in_dsp_write),
    .in_dsp_write_enable(in_dsp_write_enable), .out_dsp_ack(out_dsp_ack),
    .out_dsp_read(out_dsp_read), .out_dsp_read_valid(out_dsp_read_valid),
    .out_ram_address(out_ram_address), .out_ram_write(out_ram_write),
    .out_ram_write_enable(out_ram_write_enable), .in_ram_read(in_ram_read)
  );

  // RAM macro seen by the DUT, and the reference image updated in grant order.
  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  assign in_ram_read = ram_mem[out_ram_address];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for the current cycle.
  int e_cpu_ack, e_dsp_ack, e_we, e_addr, e_wd;
  int e_cpu_rv, e_cpu_rd, e_dsp_rv, e_dsp_rd;
  // Reads currently on the RAM port, per requester, and the data they must return.
  int iss_cpu_v, iss_cpu_d, iss_dsp_v, iss_dsp_d;
  int m_wait;

  // Bench requesters: one outstanding transaction each.
  int c_busy, c_addr, c_we, c_wd;
  int d_busy, d_addr, d_we, d_wd;

  // Advance the model by one clock using the inputs driven this cycle.
  task automatic model_step();
    int ec, ed, gc, gd;
    if (reset) begin
      e_cpu_ack = 0; e_dsp_ack = 0; e_we = 0; e_addr = 0; e_wd = 0;
      e_cpu_rv = 0; e_cpu_rd = 0; e_dsp_rv = 0; e_dsp_rd = 0;
      iss_cpu_v = 0; iss_dsp_v = 0; iss_cpu_d = 0; iss_dsp_d = 0; m_wait = 0;
      return;
    end
    ec = (in_cpu_req && e_cpu_ack == 0) ? 1 : 0;
    ed = (in_dsp_req && e_dsp_ack == 0) ? 1 : 0;
    if (ec == 1 && ed == 1) gc = (m_wait >= MAXW) ? 1 : 0;
    else gc = ec;
    gd = (ed == 1 && gc == 0) ? 1 : 0;
    if (gc == 1 || !in_cpu_req) m_wait = 0;
    else if (ec == 1 && ed == 1) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;

    e_cpu_rv = iss_cpu_v;
    if (iss_cpu_v == 1) e_cpu_rd = iss_cpu_d;
    e_dsp_rv = iss_dsp_v;
    if (iss_dsp_v == 1) e_dsp_rd = iss_dsp_d;
    iss_cpu_v = 0; iss_dsp_v = 0;

    e_cpu_ack = gc; e_dsp_ack = gd; e_we = 0;
    if (gc == 1) begin
      e_addr = int'(in_cpu_address); e_wd = int'(in_cpu_write); e_we = in_cpu_write_enable ? 1 : 0;
      if (in_cpu_write_enable) ref_mem[in_cpu_address] = in_cpu_write;
      else begin iss_cpu_v = 1; iss_cpu_d = int'(ref_mem[in_cpu_address]); end
    end else if (gd == 1) begin
      e_addr = int'(in_dsp_address); e_wd = int'(in_dsp_write); e_we = in_dsp_write_enable ? 1 : 0;
      if (in_dsp_write_enable) ref_mem[in_dsp_address] = in_dsp_write;
      else begin iss_dsp_v = 1; iss_dsp_d = int'(ref_mem[in_dsp_address]); end
    end
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) != 0) return 16'h0200 + int'($urandom_range(0, 7));
    return int'($urandom_range(0, 65535));
  endfunction

  task automatic drive_inputs();
    int p;
    if (e_cpu_ack == 1) c_busy = 0;
    if (e_dsp_ack == 1) d_busy = 0;
    if (cyc < 400) p = 100;
    else if (cyc < 1100) p = 50;
    else if (cyc < 1400) p = 25;
    else p = 0;
    reset = (cyc < 2) || (cyc >= 400 && cyc < 1400 && $urandom_range(0, 49) == 0);
    if (cyc == 2) begin
      c_busy = 1; c_addr = 16'h1234; c_we = 0; c_wd = 0;
    end else if (cyc > 2) begin
      if (c_busy == 0 && int'($urandom_range(1, 100)) <= p) begin
        c_busy = 1; c_addr = pick_addr(); c_we = int'($urandom_range(0, 1)); c_wd = int'($urandom_range(0, 255));
      end
      if (d_busy == 0 && int'($urandom_range(1, 100)) <= p) begin
        d_busy = 1; d_addr = pick_addr(); d_we = int'($urandom_range(0, 1)); d_wd = int'($urandom_range(0, 255));
      end
    end
    in_cpu_req = (c_busy == 1); in_cpu_address = AW'(c_addr);
    in_cpu_write = DW'(c_wd); in_cpu_write_enable = (c_we == 1);
    in_dsp_req = (d_busy == 1); in_dsp_address = AW'(d_addr);
    in_dsp_write = DW'(d_wd); in_dsp_write_enable = (d_we == 1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram_mem[a] = DW'(a ^ (a >> 8));
      ref_mem[a] = DW'(a ^ (a >> 8));
    end
    ram_mem[16'h1234] = 8'hA5;
    ref_mem[16'h1234] = 8'hA5;
    c_busy = 0; c_addr = 0; c_we = 0; c_wd = 0;
    d_busy = 0; d_addr = 0; d_we = 0; d_wd = 0;
    e_cpu_ack = 0; e_dsp_ack = 0;
    drive_inputs();
    model_step();
    for (cyc = 1; cyc < NCYC; cyc++) begin
      @(posedge clock);
      #1;
      chk("cpu_ack",   32'(out_cpu_ack),          32'(e_cpu_ack));
      chk("dsp_ack",   32'(out_dsp_ack),          32'(e_dsp_ack));
      chk("ram_we",    32'(out_ram_write_enable), 32'(e_we));
      chk("ram_addr",  32'(out_ram_address),      32'(e_addr));
      chk("ram_wdata", 32'(out_ram_write),        32'(e_wd));
      chk("cpu_rv",    32'(out_cpu_read_valid),   32'(e_cpu_rv));
      chk("cpu_rd",    32'(out_cpu_read),         32'(e_cpu_rd));
      chk("dsp_rv",    32'(out_dsp_read_valid),   32'(e_dsp_rv));
      chk("dsp_rd",    32'(out_dsp_read),         32'(e_dsp_rd));
      // Commit a write on the RAM port; no read shares a cycle with it.
      if (out_ram_write_enable) ram_mem[out_ram_address] = out_ram_write;
      drive_inputs();
      model_step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
